// File: rtl/tpm_command_host.sv
// TIS host-side command engine: claims a locality, streams a command from a byte FIFO,
// polls STS, collects the sized response into a FWFT FIFO and hands the locality back.
module tpm_command_host #(
    parameter int LOCALITY  = 0,
    parameter int CMD_DEPTH = 1024,
    parameter int RSP_DEPTH = 1024,
    parameter int GAP       = 2,
    parameter int POLL_GAP  = 500,
    parameter int TIMEOUT   = 1 << 24,
    parameter int MAX_RSP   = RSP_DEPTH
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] hostAddr,
    output logic [7:0]  hostInData,
    output logic        hostIsWrite,
    output logic        hostStart,
    input  logic        hostIsReady,
    input  logic        hostGotResponse,
    input  logic [7:0]  hostOutData,
    input  logic [7:0]  cmdWrData,
    input  logic        cmdWren,
    output logic        cmdFull,
    input  logic        hostShouldSend,
    input  logic        hostShouldGo,
    input  logic        abort,
    input  logic        rspRden,
    output logic [7:0]  rspDout,
    output logic        rspEmpty,
    output logic        busy,
    output logic        commandDone,
    output logic        error,
    output logic [1:0]  errCode
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam logic [15:0] BASE     = 16'(LOCALITY * 4096);
    localparam logic [15:0] REG_ACC  = BASE;
    localparam logic [15:0] REG_STS  = BASE + 16'h0018;
    localparam logic [15:0] REG_FIFO = BASE + 16'h0024;

    typedef enum logic [3:0] {
        IDLE, REQ_LOC, WAIT_LOC, SEND, GO, POLL, READ,
        CMD_READY, RELINQUISH, DONE, ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] size_q, size_d;
    logic [31:0] to_q, to_d;
    logic [31:0] gap_q, gap_d;
    logic        rd_pend_q, rd_pend_d;
    logic        err_ph_q, err_ph_d;
    logic        error_q, error_d;
    logic [1:0]  errcode_q, errcode_d;

    logic        start, wr, ld_poll, can_fire, got;
    logic [15:0] addr;
    logic [7:0]  wdata;

    // ---------------- command FIFO ----------------
    logic [7:0]   cmd_mem [CMD_DEPTH];
    logic [CAW:0] cwp_q, cwp_d, crp_q, crp_d;
    logic         cmd_empty, cmd_push, cmd_pop, cmd_flush;

    assign cmd_empty = (cwp_q == crp_q);
    assign cmdFull   = (cwp_q[CAW] != crp_q[CAW]) && (cwp_q[CAW-1:0] == crp_q[CAW-1:0]);
    assign cmd_push  = cmdWren && !cmdFull;

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cwp_q[CAW-1:0]] <= cmdWrData;
    end

    always_comb begin
        cwp_d = cwp_q;
        crp_d = crp_q;
        if (cmd_push) cwp_d = cwp_q + 1'b1;
        if (cmd_pop)  crp_d = crp_q + 1'b1;
        // a byte pushed during a flush is discarded along with the rest
        if (cmd_flush) crp_d = cwp_d;
    end

    // ---------------- response FIFO ----------------
    logic [7:0]   rsp_mem [RSP_DEPTH];
    logic [RAW:0] rwp_q, rwp_d, rrp_q, rrp_d;
    logic         rsp_full, rsp_push, rsp_pop;

    assign rspEmpty = (rwp_q == rrp_q);
    assign rsp_full = (rwp_q[RAW] != rrp_q[RAW]) && (rwp_q[RAW-1:0] == rrp_q[RAW-1:0]);
    assign rsp_pop  = rspRden && !rspEmpty;
    assign rspDout  = rsp_mem[rrp_q[RAW-1:0]];

    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mem[rwp_q[RAW-1:0]] <= hostOutData;
    end

    always_comb begin
        rwp_d = rwp_q;
        rrp_d = rrp_q;
        if (rsp_push) rwp_d = rwp_q + 1'b1;
        if (rsp_pop)  rrp_d = rrp_q + 1'b1;
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        to_d      = to_q;
        err_ph_d  = err_ph_q;
        errcode_d = errcode_q;
        error_d   = 1'b0;
        start     = 1'b0;
        wr        = 1'b0;
        ld_poll   = 1'b0;
        addr      = 16'h0000;
        wdata     = 8'h00;
        cmd_pop   = 1'b0;
        cmd_flush = 1'b0;
        rsp_push  = 1'b0;
        // one read outstanding at most; stale responses drain before the next start
        can_fire  = hostIsReady && (gap_q == 32'd0) && !rd_pend_q;
        got       = hostGotResponse && rd_pend_q;

        case (state_q)
            IDLE: begin
                cnt_d    = 32'd0;
                size_d   = 32'd0;
                to_d     = 32'd0;
                err_ph_d = 1'b0;
                if (hostShouldSend) begin
                    state_d   = REQ_LOC;
                    errcode_d = 2'd0;
                end
            end
            REQ_LOC: if (can_fire) begin
                start = 1'b1; wr = 1'b1; addr = REG_ACC; wdata = 8'h02;
                state_d = WAIT_LOC;
            end
            WAIT_LOC: begin
                to_d = to_q + 32'd1;
                if (to_d == 32'(TIMEOUT)) begin
                    state_d = ERROR; errcode_d = 2'd0;
                end else if (got) begin
                    if ((hostOutData & 8'hA0) == 8'hA0) state_d = SEND;
                end else if (can_fire) begin
                    start = 1'b1; addr = REG_ACC; ld_poll = 1'b1;
                end
            end
            SEND: begin
                if (!cmd_empty) begin
                    if (can_fire) begin
                        start = 1'b1; wr = 1'b1; addr = REG_FIFO;
                        wdata = cmd_mem[crp_q[CAW-1:0]];
                        cmd_pop = 1'b1;
                    end
                end else if (hostShouldGo) begin
                    state_d = GO;
                end
            end
            GO: if (can_fire) begin
                start = 1'b1; wr = 1'b1; addr = REG_STS; wdata = 8'h20;
                state_d = POLL;
            end
            POLL: begin
                to_d = to_q + 32'd1;
                if (to_d == 32'(TIMEOUT)) begin
                    state_d = ERROR; errcode_d = 2'd0;
                end else if (got) begin
                    if ((hostOutData & 8'h90) == 8'h90) state_d = READ;
                end else if (can_fire) begin
                    start = 1'b1; addr = REG_STS; ld_poll = 1'b1;
                end
            end
            READ: begin
                if (got) begin
                    rsp_push = 1'b1;
                    cnt_d    = cnt_q + 32'd1;
                    // size is bytes 2..5, big-endian
                    if (cnt_q == 32'd2) size_d[31:24] = hostOutData;
                    if (cnt_q == 32'd3) size_d[23:16] = hostOutData;
                    if (cnt_q == 32'd4) size_d[15:8]  = hostOutData;
                    if (cnt_q == 32'd5) begin
                        size_d[7:0] = hostOutData;
                        if (size_d < 32'd10 || size_d > 32'(MAX_RSP)) begin
                            state_d = ERROR; errcode_d = 2'd1;
                        end
                    end
                end else if (cnt_q >= 32'd6 && cnt_q == size_q) begin
                    state_d = CMD_READY;
                end else if (can_fire && !rsp_full) begin
                    start = 1'b1; addr = REG_FIFO;
                end
            end
            CMD_READY: if (can_fire) begin
                start = 1'b1; wr = 1'b1; addr = REG_STS; wdata = 8'h40;
                state_d = RELINQUISH;
            end
            RELINQUISH: if (can_fire) begin
                start = 1'b1; wr = 1'b1; addr = REG_ACC; wdata = 8'h20;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            ERROR: begin
                cmd_flush = 1'b1;
                if (can_fire) begin
                    start = 1'b1; wr = 1'b1;
                    if (!err_ph_q) begin
                        addr = REG_STS; wdata = 8'h40; err_ph_d = 1'b1;
                    end else begin
                        addr = REG_ACC; wdata = 8'h20;
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // DONE and ERROR are already winding down; abort has nothing left to cut short
        if (abort && state_q != IDLE && state_q != DONE && state_q != ERROR) begin
            state_d   = ERROR;
            errcode_d = 2'd2;
            err_ph_d  = 1'b0;
            cnt_d     = cnt_q;
            start     = 1'b0;
            wr        = 1'b0;
            ld_poll   = 1'b0;
            addr      = 16'h0000;
            wdata     = 8'h00;
            cmd_pop   = 1'b0;
            rsp_push  = 1'b0;
        end
    end

    always_comb begin
        gap_d = gap_q;
        if (start)                gap_d = ld_poll ? 32'(POLL_GAP) : 32'(GAP);
        else if (gap_q != 32'd0)  gap_d = gap_q - 32'd1;
        rd_pend_d = rd_pend_q;
        if (start && !wr)         rd_pend_d = 1'b1;
        else if (hostGotResponse) rd_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            size_q    <= 32'd0;
            to_q      <= 32'd0;
            gap_q     <= 32'd0;
            rd_pend_q <= 1'b0;
            err_ph_q  <= 1'b0;
            error_q   <= 1'b0;
            errcode_q <= 2'd0;
            cwp_q     <= '0;
            crp_q     <= '0;
            rwp_q     <= '0;
            rrp_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            to_q      <= to_d;
            gap_q     <= gap_d;
            rd_pend_q <= rd_pend_d;
            err_ph_q  <= err_ph_d;
            error_q   <= error_d;
            errcode_q <= errcode_d;
            cwp_q     <= cwp_d;
            crp_q     <= crp_d;
            rwp_q     <= rwp_d;
            rrp_q     <= rrp_d;
        end
    end

    assign hostStart   = start;
    assign hostIsWrite = wr;
    assign hostAddr    = addr;
    assign hostInData  = wdata;
    assign busy        = (state_q != IDLE);
    assign commandDone = (state_q == DONE);
    assign error       = error_q;
    assign errCode     = errcode_q;

endmodule

// File: tb/tb_tpm_command_host.sv
// Directed bench for tpm_command_host with a small TIS bus responder model.
module tb_tpm_command_host;

    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] hostAddr;
    logic [7:0]  hostInData;
    logic        hostIsWrite, hostStart;
    logic        hostIsReady, hostGotResponse;
    logic [7:0]  hostOutData;
    logic [7:0]  cmdWrData;
    logic        cmdWren, cmdFull;
    logic        hostShouldSend, hostShouldGo, abort;
    logic        rspRden;
    logic [7:0]  rspDout;
    logic        rspEmpty, busy, commandDone, error;
    logic [1:0]  errCode;

    tpm_command_host #(
        .LOCALITY(2), .CMD_DEPTH(16), .RSP_DEPTH(16), .GAP(2),
        .POLL_GAP(8), .TIMEOUT(1000), .MAX_RSP(64)
    ) dut (
        .clk(clk), .resetN(resetN),
        .hostAddr(hostAddr), .hostInData(hostInData), .hostIsWrite(hostIsWrite),
        .hostStart(hostStart), .hostIsReady(hostIsReady),
        .hostGotResponse(hostGotResponse), .hostOutData(hostOutData),
        .cmdWrData(cmdWrData), .cmdWren(cmdWren), .cmdFull(cmdFull),
        .hostShouldSend(hostShouldSend), .hostShouldGo(hostShouldGo), .abort(abort),
        .rspRden(rspRden), .rspDout(rspDout), .rspEmpty(rspEmpty),
        .busy(busy), .commandDone(commandDone), .error(error), .errCode(errCode)
    );

    always #5 clk = ~clk;

    // bus responder: 3-cycle busy window per transaction, logs writes
    logic        mdl_clr;
    logic [7:0]  rsp_bytes [0:31];
    int          sts_ok_at;
    logic [15:0] wa [0:63];
    logic [7:0]  wd [0:63];
    int          wn, wn24, rn24, poll_n, done_n, err_n, lat;
    logic        pend;
    logic [7:0]  pdata;

    always @(posedge clk) begin
        if (mdl_clr) begin
            hostIsReady     <= 1'b1;
            hostGotResponse <= 1'b0;
            hostOutData     <= 8'h00;
            lat = 0; pend = 1'b0; pdata = 8'h00;
            wn = 0; wn24 = 0; rn24 = 0; poll_n = 0; done_n = 0; err_n = 0;
        end else begin
            hostGotResponse <= 1'b0;
            if (commandDone) done_n++;
            if (error) err_n++;
            if (hostStart && lat == 0) begin
                lat = 3;
                hostIsReady <= 1'b0;
                pend = !hostIsWrite;
                if (hostIsWrite) begin
                    if (wn < 64) begin wa[wn] = hostAddr; wd[wn] = hostInData; end
                    wn++;
                    if (hostAddr == 16'h2024) wn24++;
                end else if (hostAddr == 16'h2018) begin
                    poll_n++;
                    pdata = (sts_ok_at != 0 && poll_n >= sts_ok_at) ? 8'h90 : 8'h80;
                end else if (hostAddr == 16'h2024) begin
                    pdata = rsp_bytes[rn24[4:0]];
                    rn24++;
                end else begin
                    pdata = 8'hA0;
                end
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    hostIsReady <= 1'b1;
                    if (pend) begin hostGotResponse <= 1'b1; hostOutData <= pdata; end
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        cmdWrData = b; cmdWren = 1'b1;
        @(negedge clk);
        cmdWren = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, rspDout}, {24'd0, exp});
        rspRden = 1'b1;
        @(negedge clk);
        rspRden = 1'b0;
    endtask

    task automatic clr_model();
        mdl_clr = 1'b1;
        @(negedge clk);
        mdl_clr = 1'b0;
    endtask

    task automatic start_cmd(input string tag);
        int n = 0;
        hostShouldSend = 1'b1;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        hostShouldSend = 1'b0;
        chk(tag, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_n == 0 && n < 5000) begin @(negedge clk); n++; end
        chk(tag, {31'd0, done_n != 0}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_err(input string tag);
        int n = 0;
        while (err_n == 0 && n < 5000) begin @(negedge clk); n++; end
        chk(tag, {31'd0, err_n != 0}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic load_rsp10();
        for (int i = 0; i < 32; i++) rsp_bytes[i] = 8'h30 + 8'(i);
        rsp_bytes[0] = 8'h80; rsp_bytes[1] = 8'h01;
        rsp_bytes[2] = 8'h00; rsp_bytes[3] = 8'h00; rsp_bytes[4] = 8'h00; rsp_bytes[5] = 8'h0A;
    endtask

    initial begin
        int n;
        logic found;
        resetN = 1'b0; mdl_clr = 1'b1;
        cmdWrData = 8'h00; cmdWren = 1'b0; hostShouldSend = 1'b0; hostShouldGo = 1'b0;
        abort = 1'b0; rspRden = 1'b0; sts_ok_at = 0;
        for (int i = 0; i < 32; i++) rsp_bytes[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_start", {31'd0, hostStart}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {16'd0, hostAddr}, 32'd0);
        chk("rst_cmdfull", {31'd0, cmdFull}, 32'd0);
        chk("rst_rspempty", {31'd0, rspEmpty}, 32'd1);
        chk("rst_errcode", {30'd0, errCode}, 32'd0);
        resetN = 1'b1; mdl_clr = 1'b0;
        @(negedge clk);

        // normal command: 12 bytes out, STS ready on third poll, 10-byte response
        load_rsp10(); sts_ok_at = 3;
        clr_model();
        for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
        hostShouldGo = 1'b1;
        start_cmd("t45_start");
        wait_done("t45_done");
        chk("t45_done_once", done_n, 32'd1);
        chk("t45_err_none", err_n, 32'd0);
        chk("t45_polls", poll_n, 32'd3);
        chk("t45_wn", wn, 32'd16);
        chk("t45_w0a", {16'd0, wa[0]}, 32'h2000);
        chk("t45_w0d", {24'd0, wd[0]}, 32'h02);
        for (int i = 0; i < 12; i++) begin
            chk("t45_fifo_a", {16'd0, wa[1+i]}, 32'h2024);
            chk("t45_fifo_d", {24'd0, wd[1+i]}, 32'h10 + i);
        end
        chk("t45_go_a", {16'd0, wa[13]}, 32'h2018);
        chk("t45_go_d", {24'd0, wd[13]}, 32'h20);
        chk("t45_rdy_a", {16'd0, wa[14]}, 32'h2018);
        chk("t45_rdy_d", {24'd0, wd[14]}, 32'h40);
        chk("t45_rel_a", {16'd0, wa[15]}, 32'h2000);
        chk("t45_rel_d", {24'd0, wd[15]}, 32'h20);
        chk("t45_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) pop_chk("t45_rsp", rsp_bytes[i]);
        chk("t45_rsp_empty", {31'd0, rspEmpty}, 32'd1);

        // STS never ready: timeout
        sts_ok_at = 0;
        clr_model();
        push(8'hA1); push(8'hA2);
        start_cmd("t46_start");
        wait_err("t46_err");
        chk("t46_errcode", {30'd0, errCode}, 32'd0);
        chk("t46_done", done_n, 32'd0);
        chk("t46_wn24", wn24, 32'd2);
        chk("t46_last2_a", {16'd0, wa[wn-2]}, 32'h2018);
        chk("t46_last2_d", {24'd0, wd[wn-2]}, 32'h40);
        chk("t46_last1_a", {16'd0, wa[wn-1]}, 32'h2000);
        chk("t46_last1_d", {24'd0, wd[wn-1]}, 32'h20);
        chk("t46_rspempty", {31'd0, rspEmpty}, 32'd1);
        chk("t46_cmdfull", {31'd0, cmdFull}, 32'd0);

        // bad size field (4)
        load_rsp10(); rsp_bytes[5] = 8'h04; sts_ok_at = 1;
        clr_model();
        push(8'hB1); push(8'hB2);
        start_cmd("t47_start");
        wait_err("t47_err");
        chk("t47_errcode", {30'd0, errCode}, 32'd1);
        chk("t47_reads", rn24, 32'd6);
        for (int i = 0; i < 6; i++) pop_chk("t47_rsp", rsp_bytes[i]);
        chk("t47_rsp_empty", {31'd0, rspEmpty}, 32'd1);

        // response larger than the FIFO: stall and resume; command FIFO full boundary
        for (int i = 0; i < 32; i++) rsp_bytes[i] = 8'h40 + 8'(i);
        rsp_bytes[0] = 8'h80; rsp_bytes[1] = 8'h01;
        rsp_bytes[2] = 8'h00; rsp_bytes[3] = 8'h00; rsp_bytes[4] = 8'h00; rsp_bytes[5] = 8'd20;
        sts_ok_at = 1;
        clr_model();
        for (int i = 0; i < 15; i++) push(8'hC0 + 8'(i));
        chk("t48_notfull15", {31'd0, cmdFull}, 32'd0);
        push(8'hCF);
        chk("t48_full16", {31'd0, cmdFull}, 32'd1);
        push(8'hEE);
        chk("t48_full17", {31'd0, cmdFull}, 32'd1);
        start_cmd("t48_start");
        n = 0;
        while (rn24 < 16 && n < 5000) begin @(negedge clk); n++; end
        repeat (60) @(negedge clk);
        chk("t48_stall", rn24, 32'd16);
        chk("t48_busy", {31'd0, busy}, 32'd1);
        chk("t48_wn24", wn24, 32'd16);
        for (int i = 0; i < 8; i++) pop_chk("t48_rsp_a", rsp_bytes[i]);
        wait_done("t48_done");
        chk("t48_reads", rn24, 32'd20);
        for (int i = 8; i < 20; i++) pop_chk("t48_rsp_b", rsp_bytes[i]);
        chk("t48_rsp_empty", {31'd0, rspEmpty}, 32'd1);

        // abort in SEND after 3 of 8 bytes, STS.go withheld
        hostShouldGo = 1'b0;
        clr_model();
        for (int i = 0; i < 8; i++) push(8'hD0 + 8'(i));
        start_cmd("t49_start");
        n = 0;
        while (wn24 < 3 && n < 500) begin @(negedge clk); n++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_err("t49_err");
        chk("t49_errcode", {30'd0, errCode}, 32'd2);
        chk("t49_wn24", wn24, 32'd3);
        found = 1'b0;
        for (int i = 0; i < 64; i++)
            if (i < wn && wa[i] == 16'h2018 && wd[i] == 8'h20) found = 1'b1;
        chk("t49_no_go", {31'd0, found}, 32'd0);
        chk("t49_last_a", {16'd0, wa[wn-1]}, 32'h2000);
        chk("t49_last_d", {24'd0, wd[wn-1]}, 32'h20);

        // reset during READ, then a clean command (also shows the command FIFO was flushed)
        load_rsp10(); sts_ok_at = 1; hostShouldGo = 1'b1;
        clr_model();
        for (int i = 0; i < 12; i++) push(8'h60 + 8'(i));
        start_cmd("t50_start");
        chk("t50_errcode_clr", {30'd0, errCode}, 32'd0);
        chk("t50_wn24_noleft", wn24, 32'd0);
        n = 0;
        while (rn24 < 3 && n < 3000) begin @(negedge clk); n++; end
        chk("t50_in_read", {31'd0, rn24 >= 3}, 32'd1);
        resetN = 1'b0; mdl_clr = 1'b1;
        #1;
        chk("t50_rst_start", {31'd0, hostStart}, 32'd0);
        chk("t50_rst_wr", {31'd0, hostIsWrite}, 32'd0);
        chk("t50_rst_addr", {16'd0, hostAddr}, 32'd0);
        chk("t50_rst_data", {24'd0, hostInData}, 32'd0);
        chk("t50_rst_busy", {31'd0, busy}, 32'd0);
        chk("t50_rst_done", {31'd0, commandDone}, 32'd0);
        chk("t50_rst_error", {31'd0, error}, 32'd0);
        chk("t50_rst_rspempty", {31'd0, rspEmpty}, 32'd1);
        chk("t50_rst_cmdfull", {31'd0, cmdFull}, 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1; mdl_clr = 1'b0;
        @(negedge clk);
        clr_model();
        for (int i = 0; i < 12; i++) push(8'h70 + 8'(i));
        start_cmd("t50b_start");
        wait_done("t50b_done");
        chk("t50b_err", err_n, 32'd0);
        chk("t50b_wn", wn, 32'd16);
        chk("t50b_wn24", wn24, 32'd12);
        chk("t50b_last_d", {24'd0, wd[12]}, 32'h7B);
        for (int i = 0; i < 10; i++) pop_chk("t50b_rsp", rsp_bytes[i]);
        chk("t50b_rsp_empty", {31'd0, rspEmpty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
